// File: rtl/mem_arb_pkg.sv
// Shared FSM/owner encodings and default parameters for mem_arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GNT_IF = 2'd1,
      GNT_D  = 2'd2,
      RESP   = 2'd3
   } arb_state_e;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_D    = 2'd2
   } owner_e;

   localparam int DEF_ADDR_W       = 32;
   localparam int DEF_DATA_W       = 32;
   localparam int DEF_TIMEOUT_CYC  = 15;
   localparam int DEF_STARVE_LIMIT = 4;

endpackage

// File: rtl/mem_arb_timer.sv
// Loadable down-counter; expired_o flags the last permitted cycle of a grant.
module mem_arb_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             expired_o
);

   logic [CNT_W-1:0] cnt_q;

   // Reload while idle, count down while a grant is outstanding
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= {CNT_W{1'b0}};
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (en_i && (cnt_q != {CNT_W{1'b0}})) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end else begin
         cnt_q <= cnt_q;
      end
   end

   assign expired_o = en_i && (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (fetch/data) single-memory arbiter with timeout.
// Define MEM_ARB_FAIRNESS_EN to bound how long a data stream can starve fetch.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic [DATA_W-1:0]   if_rdata,
   output logic                if_ack,
   output logic                if_err,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_wdata,
   input  logic [DATA_W/8-1:0] d_be,
   output logic [DATA_W-1:0]   d_rdata,
   output logic                d_ack,
   output logic                d_err,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_ack
);

   localparam int BE_W  = DATA_W / 8;
   localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

   arb_state_e state_q;
   owner_e     owner_q;
   logic       in_grant_s;
   logic       idle_s;
   logic       tmr_expired_s;
   logic       force_if_s;
   logic       grant_d_s;
   logic       grant_if_s;

   assign idle_s     = (state_q == IDLE);
   assign in_grant_s = (state_q == GNT_IF) || (state_q == GNT_D);

   mem_arb_timer #(.CNT_W(TMR_W)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (idle_s),
      .en_i       (in_grant_s),
      .load_val_i (TMR_W'(TIMEOUT_CYC - 1)),
      .expired_o  (tmr_expired_s)
   );

`ifdef MEM_ARB_FAIRNESS_EN
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);
   logic [STV_W-1:0] starve_q;

   // Count data grants taken while fetch was waiting; a fetch grant resets it
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_q <= {STV_W{1'b0}};
      end else if (grant_if_s) begin
         starve_q <= {STV_W{1'b0}};
      end else if (grant_d_s && if_req && (starve_q < STV_W'(STARVE_LIMIT))) begin
         starve_q <= starve_q + STV_W'(1);
      end else begin
         starve_q <= starve_q;
      end
   end

   assign force_if_s = if_req && (starve_q >= STV_W'(STARVE_LIMIT));
`else
   assign force_if_s = 1'b0 && (STARVE_LIMIT > 0);
`endif

   // Arbitration decision, only meaningful in IDLE
   always_comb begin
      grant_d_s  = 1'b0;
      grant_if_s = 1'b0;
      if (idle_s) begin
         if (force_if_s) begin
            grant_if_s = 1'b1;
         end else if (d_req) begin
            grant_d_s = 1'b1;
         end else begin
            grant_if_s = if_req;
         end
      end else begin
         grant_d_s  = 1'b0;
         grant_if_s = 1'b0;
      end
   end

   // Main FSM with registered memory-side and response outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         owner_q   <= OWN_NONE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= {ADDR_W{1'b0}};
         mem_wdata <= {DATA_W{1'b0}};
         mem_be    <= {BE_W{1'b0}};
         if_rdata  <= {DATA_W{1'b0}};
         d_rdata   <= {DATA_W{1'b0}};
         if_ack    <= 1'b0;
         if_err    <= 1'b0;
         d_ack     <= 1'b0;
         d_err     <= 1'b0;
      end else begin
         if_ack <= 1'b0;
         if_err <= 1'b0;
         d_ack  <= 1'b0;
         d_err  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (grant_d_s) begin
                  state_q   <= GNT_D;
                  owner_q   <= OWN_D;
                  mem_req   <= 1'b1;
                  mem_we    <= d_we;
                  mem_addr  <= d_addr;
                  mem_wdata <= d_wdata;
                  mem_be    <= d_be;
               end else if (grant_if_s) begin
                  state_q   <= GNT_IF;
                  owner_q   <= OWN_IF;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_addr  <= if_addr;
                  mem_wdata <= {DATA_W{1'b0}};
                  mem_be    <= {BE_W{1'b1}};
               end else begin
                  state_q <= IDLE;
                  owner_q <= OWN_NONE;
               end
            end
            GNT_IF, GNT_D: begin
               // An ack arriving in the final permitted cycle still wins over timeout
               if (mem_ack || tmr_expired_s) begin
                  state_q <= RESP;
                  mem_req <= 1'b0;
                  if (owner_q == OWN_D) begin
                     d_ack   <= 1'b1;
                     d_err   <= ~mem_ack;
                     d_rdata <= mem_ack ? mem_rdata : {DATA_W{1'b0}};
                  end else begin
                     if_ack   <= 1'b1;
                     if_err   <= ~mem_ack;
                     if_rdata <= mem_ack ? mem_rdata : {DATA_W{1'b0}};
                  end
               end else begin
                  state_q <= state_q;
               end
            end
            RESP: begin
               state_q <= IDLE;
               owner_q <= OWN_NONE;
            end
            default: begin
               state_q <= IDLE;
               owner_q <= OWN_NONE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter against a transaction-level model.
module tb_mem_arbiter;

   localparam int TO = 15;
   localparam int SL = 4;
`ifdef MEM_ARB_FAIRNESS_EN
   localparam bit FAIR = 1'b1;
`else
   localparam bit FAIR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_ack;
   logic        if_err;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_be;
   logic [31:0] d_rdata;
   logic        d_ack;
   logic        d_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   int          tests = 0;
   int          fails = 0;
   logic [31:0] m_if_rd = 32'h0;
   logic [31:0] m_d_rd  = 32'h0;
   int          starve  = 0;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO), .STARVE_LIMIT(SL)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_err(if_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_mem_req"},   32'(mem_req),   32'h0);
      chk({tag, "_mem_we"},    32'(mem_we),    32'h0);
      chk({tag, "_mem_addr"},  mem_addr,       32'h0);
      chk({tag, "_mem_wdata"}, mem_wdata,      32'h0);
      chk({tag, "_mem_be"},    32'(mem_be),    32'h0);
      chk({tag, "_if_ack"},    32'(if_ack),    32'h0);
      chk({tag, "_if_err"},    32'(if_err),    32'h0);
      chk({tag, "_d_ack"},     32'(d_ack),     32'h0);
      chk({tag, "_d_err"},     32'(d_err),     32'h0);
      chk({tag, "_if_rdata"},  if_rdata,       32'h0);
      chk({tag, "_d_rdata"},   d_rdata,        32'h0);
   endtask

   task automatic chk_idle();
      chk("idle_mem_req", 32'(mem_req), 32'h0);
      chk("idle_if_ack",  32'(if_ack),  32'h0);
      chk("idle_if_err",  32'(if_err),  32'h0);
      chk("idle_d_ack",   32'(d_ack),   32'h0);
      chk("idle_d_err",   32'(d_err),   32'h0);
      chk("idle_if_rdata_hold", if_rdata, m_if_rd);
      chk("idle_d_rdata_hold",  d_rdata,  m_d_rd);
   endtask

   // Memory side: ack lat cycles after the first grant cycle (lat<0: never).
   task automatic serve(input int lat, input logic [31:0] rd, input logic [31:0] ea,
                        input logic ewe, input logic [3:0] ebe, input logic [31:0] ewd,
                        input bit is_if);
      bit done;
      done = 1'b0;
      for (int k = 1; k <= TO && !done; k++) begin
         chk("grant_mem_req", 32'(mem_req), 32'h1);
         chk("grant_mem_addr", mem_addr, ea);
         chk("grant_mem_we", 32'(mem_we), 32'(ewe));
         chk("grant_mem_be", 32'(mem_be), 32'(ebe));
         if (!is_if) chk("grant_mem_wdata", mem_wdata, ewd);
         if (lat >= 0 && k == lat + 1) begin
            mem_ack   = 1'b1;
            mem_rdata = rd;
            done      = 1'b1;
         end else begin
            mem_rdata = $urandom();
         end
         if (k == TO) done = 1'b1;
         tick();
         mem_ack = 1'b0;
      end
   endtask

   task automatic check_resp(input bit is_if, input int lat, input logic [31:0] rd);
      bit ok;
      ok = (lat >= 0) && (lat + 1 <= TO);
      if (is_if) m_if_rd = ok ? rd : 32'h0;
      else       m_d_rd  = ok ? rd : 32'h0;
      chk("resp_mem_req_low", 32'(mem_req), 32'h0);
      chk("resp_if_ack", 32'(if_ack), 32'(is_if));
      chk("resp_if_err", 32'(if_err), 32'(is_if && !ok));
      chk("resp_d_ack",  32'(d_ack),  32'(!is_if));
      chk("resp_d_err",  32'(d_err),  32'(!is_if && !ok));
      chk("resp_if_rdata", if_rdata, m_if_rd);
      chk("resp_d_rdata",  d_rdata,  m_d_rd);
   endtask

   // One or two requesters raised together from IDLE; each dropped on its ack.
   task automatic run_round(input bit use_d, input bit use_if, input int lat_d, input int lat_if,
                            input logic [31:0] rd_d, input logic [31:0] rd_if);
      bit          pend_d, pend_if, win_if;
      logic [31:0] ea, ewd, rd;
      logic [3:0]  ebe;
      logic        ewe;
      int          lat;
      pend_d  = use_d;
      pend_if = use_if;
      d_req   = use_d;
      if_req  = use_if;
      for (int g = 0; g < 2 && (pend_d || pend_if); g++) begin
         win_if = pend_if && (!pend_d || (FAIR && starve >= SL));
         if (win_if) begin
            ea = if_addr; ewe = 1'b0; ebe = 4'hF; ewd = 32'h0; lat = lat_if; rd = rd_if;
            starve = 0;
         end else begin
            ea = d_addr; ewe = d_we; ebe = d_be; ewd = d_wdata; lat = lat_d; rd = rd_d;
            if (pend_if) starve++;
         end
         tick();
         if (win_if) begin
            if_addr = ~ea;
         end else begin
            d_addr  = ~ea;
            d_wdata = ~ewd;
         end
         serve(lat, rd, ea, ewe, ebe, ewd, win_if);
         check_resp(win_if, lat, rd);
         if (win_if) begin
            if_req = 1'b0; pend_if = 1'b0;
         end else begin
            d_req = 1'b0; pend_d = 1'b0;
         end
         tick();
         chk_idle();
      end
   endtask

   initial begin
      bit          wi;
      int          mode, lat_d, lat_i;
      logic [31:0] ea, rd;

      rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; d_req = 1'b0; d_we = 1'b0;
      d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
      repeat (3) tick();
      chk_all_zero("reset");
      rst = 1'b0;
      tick();
      chk_idle();

      // Fetch-only read, ack two cycles after mem_req
      if_addr = 32'h100;
      run_round(1'b0, 1'b1, -1, 2, 32'h0, 32'h13);

      // Simultaneous requests: data write first, fetch after one idle cycle
      d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_be = 4'hF; if_addr = 32'h400;
      run_round(1'b1, 1'b1, 1, 0, 32'h5555AAAA, 32'h00C0FFEE);

      // Data read that never sees mem_ack
      d_we = 1'b0; d_addr = 32'h2004; d_wdata = 32'h0; d_be = 4'hF;
      run_round(1'b1, 1'b0, -1, 0, 32'h0, 32'h0);

      // Spurious mem_ack in IDLE is ignored
      mem_ack = 1'b1; mem_rdata = 32'h12345678;
      tick();
      mem_ack = 1'b0;
      chk_idle();
      tick();
      chk_idle();
      if_addr = 32'h104;
      run_round(1'b0, 1'b1, 0, 0, 32'h0, 32'h87654321);

      // Reset three cycles into a data grant
      d_we = 1'b1; d_addr = 32'h3000; d_wdata = 32'hA5A5A5A5; d_be = 4'h3; d_req = 1'b1;
      tick();
      chk("pre_rst_mem_req", 32'(mem_req), 32'h1);
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk_all_zero("mid_rst");
      m_if_rd = 32'h0; m_d_rd = 32'h0; starve = 0;
      rst = 1'b0; d_req = 1'b0;
      for (int c = 0; c < TO + 2; c++) begin
         tick();
         chk("post_rst_d_ack", 32'(d_ack), 32'h0);
         chk("post_rst_mem_req", 32'(mem_req), 32'h0);
      end

      // Data requested continuously alongside a waiting fetch
      d_we = 1'b0; d_addr = 32'hA000; d_be = 4'hF; if_addr = 32'hB000;
      d_req = 1'b1; if_req = 1'b1;
      for (int g = 0; g < 6; g++) begin
         wi = FAIR && if_req && (starve >= SL);
         if (wi) starve = 0;
         else if (if_req) starve++;
         ea = wi ? if_addr : d_addr;
         rd = $urandom();
         tick();
         serve(0, rd, ea, 1'b0, 4'hF, d_wdata, wi);
         check_resp(wi, 0, rd);
         if (wi) if_req = 1'b0;
         tick();
         chk_idle();
      end
      d_req = 1'b0;
      if (if_req) begin
         starve = 0;
         rd = $urandom();
         tick();
         serve(1, rd, if_addr, 1'b0, 4'hF, 32'h0, 1'b1);
         check_resp(1'b1, 1, rd);
         if_req = 1'b0;
         tick();
         chk_idle();
      end

      // Randomized rounds
      for (int r = 0; r < 16; r++) begin
         mode    = $urandom_range(0, 2);
         lat_d   = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TO));
         lat_i   = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TO));
         d_we    = 1'($urandom_range(0, 1));
         d_addr  = $urandom();
         d_wdata = $urandom();
         d_be    = 4'($urandom_range(0, 15));
         if_addr = $urandom();
         if ($urandom_range(0, 3) == 0) begin
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
            chk_idle();
         end
         run_round(mode != 0, mode != 1, lat_d, lat_i, $urandom(), $urandom());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
